fakeram7_req_adapter: RTL and testbench
=======================================

// Module: fakeram7_req_adapter
// PURPOSE
//  Valid/ready request front-end that sits directly upstream of the fakeram7_64x21 single-port macro.
//  Serialises read/write requests onto the macro pins and tracks the macro's 1-cycle read latency.
//  Returns read data through a credit-checked response FIFO.
//  Guarantees the macro never sees X on we/addr, since X there corrupts the whole array.
// PARAMETERS
//  BITS        21  data width; matches the macro word
//  ADDR_WIDTH  6   address width; 64 words
//  RESP_DEPTH  4   response FIFO entries; >=3 gives 1 read/cycle sustained, min 2
// PORTS
//  clk          in   1           single clock; also drives the macro clk
//  rst          in   1           synchronous, active-high reset
//  req_valid    in   1           request present
//  req_ready    out  1           adapter accepts request this cycle
//  req_we       in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  word address
//  req_wdata    in   BITS        write data; macro ORs it into the stored word
//  resp_valid   out  1           read data available
//  resp_ready   in   1           consumer takes resp_rdata
//  resp_rdata   out  BITS        read data, in request order
//  ram_ce       out  1           to macro ce_in
//  ram_we       out  1           to macro we_in
//  ram_addr     out  ADDR_WIDTH  to macro addr_in
//  ram_wd       out  BITS        to macro wd_in
//  ram_rd       in   BITS        from macro rd_out; valid only in the cycle after a read issue
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - resp_valid=0, FIFO count=0, inflight_rd=0.
//   - req_ready=0 and ram_ce=0 while rst is high.
//   - Mid-operation reset: drop any inflight read, flush the FIFO, ignore ram_rd on the following cycle.
//  Issue:
//   - fire = req_valid & req_ready.
//   - On fire, the same cycle drives ram_ce=1, ram_we=req_we, ram_addr=req_addr, ram_wd=req_we ? req_wdata : 0.
//   - Combinational pass-through; no added latency on the request path.
//  Idle (no fire):
//   - ram_ce=0, ram_we=0, ram_addr=0, ram_wd=0. Never X.
//  Writes:
//   - Posted; no response generated.
//   - Stored result = old | wdata. Clearing bits is not possible through this port.
//  Reads:
//   - inflight_rd <= fire & ~req_we.
//   - When inflight_rd=1, push ram_rd into the FIFO at the next posedge.
//   - Read latency, fire to earliest resp_valid: 2 cycles.
//  Credit rule:
//   - req_ready = ~rst & ((count + inflight_rd) < RESP_DEPTH).
//   - Uses registered state only; no combinational path from resp_ready to req_ready.
//   - Writes also wait on req_ready. Simpler; accepted throughput cost.
//  FIFO:
//   - resp_valid = (count != 0); resp_rdata = head entry.
//   - Pop on resp_valid & resp_ready.
//   - Push and pop in the same cycle: count unchanged, pointers both advance.
//   - Pointers wrap modulo RESP_DEPTH.
//   - Overflow is impossible by the credit rule; assert (count==RESP_DEPTH) -> ~inflight_rd.
//  Hazards:
//   - Read then write to the same address on back-to-back cycles: the read returns the pre-write value.
//   - A read issued the cycle after a write returns the merged value.
//   - Response order always equals read issue order.
// STRUCTURE
//  - Package fakeram7_adapter_pkg: BITS, ADDR_WIDTH localparams; typedef word_t, addr_t.
//  - Sub-module fakeram7_resp_fifo: sync FIFO with push/pop/count/head; data not reset, pointers reset.
//  - Top level: issue mux, inflight_rd flop, credit compare. Target 150-250 lines total.
// TESTING
//  - Reset: hold rst 3 cycles with req_valid=1 -> req_ready=0, ram_ce=0, resp_valid=0 throughout.
//  - Write/read: write addr 5 data 0x00F0F0, then read addr 5 -> resp_rdata=0x00F0F0, 2 cycles after read fire.
//  - OR-merge: write addr 9 0x000003, write addr 9 0x000100, read addr 9 -> 0x000103.
//  - Back-pressure: resp_ready=0, 6 reads to addr 0..5 -> exactly 4 accepted, then req_ready=0.
//    Release resp_ready -> data returned in order 0..3; remaining 2 reads then proceed.
//  - Throughput: resp_ready=1, 16 consecutive reads -> req_ready stays 1 and one resp per cycle after a 2-cycle fill.
//  - Mid-operation reset: assert rst the cycle after a read fire -> no resp_valid afterwards.
//    With 2 entries queued at reset, both are flushed and no X is ever seen on ram_we/ram_addr (X-check assertion).

Source files
------------

// File: rtl/fakeram7_adapter_pkg.sv
// Shared word/address types for the fakeram7_64x21 request front-end.
// The macro geometry is fixed, so width constants live here rather than as top parameters.
package fakeram7_adapter_pkg;

   localparam int unsigned BITS       = 21;
   localparam int unsigned ADDR_WIDTH = 6;

   typedef logic [BITS-1:0]       word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/fakeram7_resp_fifo.sv
// Synchronous response FIFO: registered head/count, pointers wrap modulo DEPTH.
// Storage is not reset; only pointers and occupancy are.
module fakeram7_resp_fifo
   import fakeram7_adapter_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  word_t         push_data_i,
   input  logic          pop_i,
   output logic [CW-1:0] count_o,
   output word_t         head_o
);

   word_t         mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fakeram7_req_adapter.sv
// Valid/ready front-end for the fakeram7_64x21 macro: combinational issue onto the
// macro pins, one-cycle read-latency tracking, and a credit-checked response FIFO.
module fakeram7_req_adapter
   import fakeram7_adapter_pkg::*;
#(
   parameter int unsigned RESP_DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  req_valid,
   output logic  req_ready,
   input  logic  req_we,
   input  addr_t req_addr,
   input  word_t req_wdata,
   output logic  resp_valid,
   input  logic  resp_ready,
   output word_t resp_rdata,
   output logic  ram_ce,
   output logic  ram_we,
   output addr_t ram_addr,
   output word_t ram_wd,
   input  word_t ram_rd
);

   localparam int unsigned CW      = $clog2(RESP_DEPTH + 1);
   localparam logic [CW:0] LIMIT_C = (CW + 1)'(RESP_DEPTH);
   localparam logic [CW-1:0] FULL_C = CW'(RESP_DEPTH);

   logic          fire;
   logic          inflight_q, inflight_d;
   logic          push, pop;
   logic [CW-1:0] count;
   logic [CW:0]   credit_used;

   // Credit counts queued entries plus the read still in the macro; registered state only.
   assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign req_ready   = ~rst & (credit_used < LIMIT_C);
   assign fire        = req_valid & req_ready;

   always_comb begin
      ram_ce   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_wd   = '0;
      if (fire) begin
         ram_ce   = 1'b1;
         ram_we   = req_we;
         ram_addr = req_addr;
         ram_wd   = req_we ? req_wdata : '0;
      end
   end

   assign inflight_d = fire & ~req_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   assign push       = inflight_q & ~rst;
   assign resp_valid = (count != '0);
   assign pop        = resp_valid & resp_ready;

   fakeram7_resp_fifo #(
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (ram_rd),
      .pop_i       (pop),
      .count_o     (count),
      .head_o      (resp_rdata)
   );

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (count == FULL_C) |-> !inflight_q);

   a_pins_known : assert property (@(posedge clk)
      !$isunknown({ram_ce, ram_we, ram_addr}));

endmodule

// File: tb/tb_fakeram7_req_adapter.sv
// Self-checking bench: behavioural macro plus a queue-based reference of the adapter contract.
module tb_fakeram7_req_adapter;
   import fakeram7_adapter_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic  clk = 1'b0;
   logic  rst, req_valid, req_ready, req_we;
   addr_t req_addr;
   word_t req_wdata;
   logic  resp_valid, resp_ready;
   word_t resp_rdata;
   logic  ram_ce, ram_we;
   addr_t ram_addr;
   word_t ram_wd;
   word_t ram_rd = '0;

   always #5 clk = ~clk;

   fakeram7_req_adapter #(
      .RESP_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .ram_ce     (ram_ce),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wd     (ram_wd),
      .ram_rd     (ram_rd)
   );

   // Macro: write ORs into the word, read data valid only the cycle after issue, junk otherwise.
   word_t mac_mem [64] = '{default: '0};
   always @(posedge clk) begin
      if (ram_ce === 1'b1 && ram_we === 1'b1) mac_mem[ram_addr] <= mac_mem[ram_addr] | ram_wd;
      if (ram_ce === 1'b1 && ram_we === 1'b0) ram_rd <= mac_mem[ram_addr];
      else ram_rd <= word_t'($urandom);
   end

   typedef struct {
      word_t       data;
      int unsigned avail;
   } exp_t;

   exp_t        exp_q[$];
   word_t       ref_mem [64] = '{default: '0};
   word_t       got_q[$];
   int unsigned cyc = 0;
   int          tests = 0, fails = 0, err_cnt = 0;
   string       first_err;
   logic        obs_ready, obs_ce, obs_rv;
   word_t       obs_rdata;

   // One clock: compare DUT against the reference at negedge, advance the reference at posedge.
   task automatic tick();
      bit    e_ready, e_fire, e_rv, e_we;
      addr_t e_addr;
      word_t e_wd;
      exp_t  ent;
      string msg;
      @(negedge clk);
      e_ready = !rst && (exp_q.size() < DEPTH);
      e_fire  = e_ready && req_valid;
      e_rv    = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
      e_we    = e_fire && req_we;
      e_addr  = e_fire ? req_addr : '0;
      e_wd    = e_we ? req_wdata : '0;
      obs_ready = req_ready;
      obs_ce    = ram_ce;
      obs_rv    = resp_valid;
      obs_rdata = resp_rdata;
      msg = "";
      if (req_ready !== e_ready)
         msg = $sformatf("cyc %0d req_ready got %b want %b", cyc, req_ready, e_ready);
      else if (ram_ce !== e_fire || ram_we !== e_we || ram_addr !== e_addr || ram_wd !== e_wd)
         msg = $sformatf("cyc %0d pins got ce=%b we=%b addr=%h wd=%h want ce=%b we=%b addr=%h wd=%h",
                         cyc, ram_ce, ram_we, ram_addr, ram_wd, e_fire, e_we, e_addr, e_wd);
      else if (resp_valid !== e_rv)
         msg = $sformatf("cyc %0d resp_valid got %b want %b", cyc, resp_valid, e_rv);
      else if (e_rv && resp_rdata !== exp_q[0].data)
         msg = $sformatf("cyc %0d resp_rdata got %h want %h", cyc, resp_rdata, exp_q[0].data);
      if (msg != "") begin
         if (err_cnt == 0) first_err = msg;
         err_cnt++;
      end
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
      end else begin
         if (e_rv && resp_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back(obs_rdata);
         end
         if (e_fire) begin
            if (req_we) begin
               ref_mem[req_addr] = ref_mem[req_addr] | req_wdata;
            end else begin
               ent.data  = ref_mem[req_addr];
               ent.avail = cyc + 2;
               exp_q.push_back(ent);
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      err_cnt = 0;
      rst = 1'b1; req_valid = 1'b1; resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_we = 1'($urandom); req_addr = addr_t'($urandom); req_wdata = word_t'($urandom);
         tick();
         tests++;
         if (obs_ready !== 1'b0 || obs_ce !== 1'b0 || obs_rv !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold[%0d]: ready=%b ce=%b resp_valid=%b want 0 0 0", i, obs_ready, obs_ce, obs_rv);
         end
      end
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      tick();
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL reset_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   task automatic test_write_read();
      err_cnt = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 21'h00F0F0; tick();
      req_we = 1'b0; req_wdata = '0; tick();
      req_valid = 1'b0; tick();
      tests++;
      if (obs_rv !== 1'b0) begin fails++; $display("FAIL wr_rd_early: resp_valid got %b want 0", obs_rv); end
      tick();
      tests++;
      if (obs_rv !== 1'b1 || obs_rdata !== 21'h00F0F0) begin
         fails++; $display("FAIL wr_rd_data: valid=%b data=%h want 1 00f0f0", obs_rv, obs_rdata);
      end
      tick();
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL wr_rd_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   task automatic test_or_merge();
      err_cnt = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd9;
      req_wdata = 21'h000003; tick();
      req_wdata = 21'h000100; tick();
      req_we = 1'b0; req_wdata = '0; tick();
      req_valid = 1'b0; tick(); tick();
      tests++;
      if (obs_rv !== 1'b1 || obs_rdata !== 21'h000103) begin
         fails++; $display("FAIL or_merge: valid=%b data=%h want 1 000103", obs_rv, obs_rdata);
      end
      tick();
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL or_merge_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   task automatic test_back_to_back();
      err_cnt = 0; got_q.delete();
      req_valid = 1'b1; req_addr = 6'd40;
      req_we = 1'b1; req_wdata = 21'h000001; tick();
      req_we = 1'b0; req_wdata = '0;         tick();
      req_we = 1'b1; req_wdata = 21'h000010; tick();
      req_we = 1'b0; req_wdata = '0;         tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      tests++;
      if (got_q.size() != 2) begin
         fails++; $display("FAIL b2b_count: got %0d responses want 2", got_q.size());
      end else begin
         tests++;
         if (got_q[0] !== 21'h000001 || got_q[1] !== 21'h000011) begin
            fails++; $display("FAIL b2b_hazard: got %h %h want 000001 000011", got_q[0], got_q[1]);
         end
      end
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL b2b_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   task automatic test_back_pressure();
      word_t       wv [6];
      int unsigned acc;
      err_cnt = 0; resp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wv[i] = word_t'($urandom); req_addr = addr_t'(i); req_wdata = wv[i]; tick();
      end
      wv[5] = wv[5] | 21'h00F0F0;
      resp_ready = 1'b0; req_we = 1'b0; req_wdata = '0; acc = 0; got_q.delete();
      for (int i = 0; i < 8; i++) begin
         req_addr = addr_t'(acc); tick();
         if (obs_ready === 1'b1) acc++;
      end
      tests++;
      if (acc !== 4) begin fails++; $display("FAIL bp_accepted: got %0d want 4", acc); end
      tests++;
      if (obs_ready !== 1'b0) begin fails++; $display("FAIL bp_stall: req_ready got %b want 0", obs_ready); end
      resp_ready = 1'b1;
      for (int i = 0; i < 30 && got_q.size() < 6; i++) begin
         req_valid = (acc < 6); req_addr = addr_t'((acc < 6) ? acc : 0); tick();
         if (req_valid && obs_ready === 1'b1) acc++;
      end
      req_valid = 1'b0;
      tests++;
      if (got_q.size() != 6) begin
         fails++; $display("FAIL bp_drain: got %0d responses want 6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_q[i] !== wv[i]) begin fails++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], wv[i]); end
         end
      end
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL bp_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   task automatic test_throughput();
      logic        rv_log [20];
      int unsigned nrdy;
      err_cnt = 0; resp_ready = 1'b1; req_we = 1'b0; req_wdata = '0; nrdy = 0;
      for (int i = 0; i < 20; i++) begin
         req_valid = (i < 16); req_addr = addr_t'($urandom_range(0, 63)); tick();
         if (i < 16 && obs_ready !== 1'b1) nrdy++;
         rv_log[i] = obs_rv;
      end
      req_valid = 1'b0;
      tests++;
      if (nrdy !== 0) begin fails++; $display("FAIL tput_ready: %0d stalled cycles want 0", nrdy); end
      for (int i = 0; i < 20; i++) begin
         tests++;
         if (rv_log[i] !== 1'((i >= 2) && (i < 18))) begin
            fails++; $display("FAIL tput_resp[%0d]: resp_valid got %b want %b", i, rv_log[i], (i >= 2) && (i < 18));
         end
      end
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL tput_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   task automatic test_mid_reset();
      int unsigned nrv;
      err_cnt = 0; resp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5; tick();
      req_valid = 1'b0; rst = 1'b1; tick();
      rst = 1'b0; nrv = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (obs_rv !== 1'b0) nrv++; end
      tests++;
      if (nrv !== 0) begin fails++; $display("FAIL mrst_inflight: %0d resp_valid cycles want 0", nrv); end
      resp_ready = 1'b0; req_valid = 1'b1; req_addr = 6'd9; tick();
      req_addr = 6'd40; tick();
      req_valid = 1'b0; tick(); tick(); tick();
      rst = 1'b1; tick();
      tests++;
      if (obs_rv !== 1'b1) begin fails++; $display("FAIL mrst_queued: resp_valid got %b want 1", obs_rv); end
      rst = 1'b0; resp_ready = 1'b1; nrv = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (obs_rv !== 1'b0) nrv++; end
      tests++;
      if (nrv !== 0) begin fails++; $display("FAIL mrst_flush: %0d resp_valid cycles want 0", nrv); end
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL mrst_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   task automatic test_random();
      err_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         req_valid  = ($urandom_range(0, 3) != 0);
         req_we     = 1'($urandom);
         req_addr   = addr_t'($urandom);
         req_wdata  = word_t'($urandom & $urandom & $urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      tests++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL rand_drain: %0d responses outstanding want 0", exp_q.size()); end
      tests++;
      if (err_cnt !== 0) begin fails++; $display("FAIL rand_model: %0d mismatches want 0, first: %s", err_cnt, first_err); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      test_reset();
      test_write_read();
      test_or_merge();
      test_back_to_back();
      test_back_pressure();
      test_throughput();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

endmodule
